seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the operator display drivers: watches the multiplexed seven-segment bus (segment pattern plus digit enables) and reconstructs which symbol is on each of the four digits.
- Used in benches and on-board self-check to turn scanned display output back into per-digit codes, a decimal-point mask and a frame-complete strobe.
- A glitch filter rejects scan transitions and ghosting.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples of {a_to_g, seg_en} required before a digit is accepted (legal range 2..255).
- CNT_W, 8, stability counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- a_to_g  in  8  segment bus, active-high; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp
- seg_en  in  4  digit enables, active-high; bit3 = leftmost digit
- digits  out  20  frame result; digit k symbol at [5k+4:5k]
- dp  out  4  frame result: decimal point per digit
- frame_valid  out  1  one-cycle pulse when digits/dp update
- pat_err  out  1  one-cycle pulse: accepted pattern is not in the symbol table
- en_err  out  1  one-cycle pulse: seg_en became multi-hot

Behaviour:
- Reset (clk edge with rst=1) sets:
  - digits to 0 and dp to 0.
  - frame_valid, pat_err and en_err to 0.
  - Capture mask to 0, stability counter to 0, FSM to IDLE.
  - Sample register to 0.
- Symbol table, keyed on a..g with dp ignored:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Blank 0000000 decodes to code 16; minus 0000001 decodes to 17.
  - Any other pattern decodes to code 31.
- Sampling: each cycle register {a_to_g, seg_en} into the sample register. "Changed" means the current input differs from the sample register.
- FSM states:
  - IDLE: seg_en==0. Counter is held at 0 and nothing is captured. When seg_en becomes one-hot, go to SETTLE with counter=0.
  - SETTLE: if changed, counter=0; a zero seg_en returns to IDLE, a multi-hot seg_en goes to BAD. Otherwise counter increments. When counter==STABLE_CYCLES-1 on an unchanged sample, capture and go to HELD.
  - HELD: the digit has been captured. Stay until changed, then handle as the corresponding entry into IDLE, SETTLE or BAD.
  - BAD: seg_en is multi-hot. en_err pulses on the entry cycle only. No capture. Leave on change as from HELD.
- Capture (one cycle):
  - Write the symbol and dp into the staging slot selected by the one-hot index; set that mask bit.
  - If the decoded code is 31, pulse pat_err in the same cycle the slot is written.
  - Re-capturing a digit already in the mask overwrites its staging slot and does not pulse frame_valid.
- Frame completion:
  - Applies when the mask becomes 4'b1111, including when it completes on this capture.
  - On the next clk: copy staging to digits/dp, pulse frame_valid for 1 cycle and clear the mask.
  - A capture landing in that same cycle sets only its own mask bit in the new frame.
- Latency:
  - An input held from cycle t is captured at the edge ending cycle t+STABLE_CYCLES-1.
  - For the 4th digit, frame_valid is high in the cycle after capture.
  - A pattern held exactly STABLE_CYCLES-1 cycles is never captured.
- Counter saturates; there is no wrap in HELD.
- Reset mid-frame discards the partial mask and staging data.

Decomposition:
- Shared package (seg_pkg): segment bit positions, the 16 hex patterns, SYM_BLANK=16, SYM_MINUS=17, SYM_INVALID=31, FSM state encoding.
- One sub-module: seg7_pattern_decode. It is purely combinational, mapping the 7 segment bits to a 5-bit symbol, and is shared with future display checkers.

Test Plan:
- Clean frame: scan seg_en 1000, 0100, 0010, 0001 showing 1, 6, blank, minus. Hold each 6 cycles with a 1-cycle seg_en=0 gap. Required: one frame_valid; digits={5'd1, 5'd6, 5'd16, 5'd17}; dp=0; no errors.
- Glitch rejection: hold "8" for STABLE_CYCLES-1 cycles, then switch to "C" for 6 cycles. Required: the digit captures 12 only, never 8.
- Invalid pattern: a..g=1010101 on digit 0 with dp=1, other digits valid. Required: pat_err pulses once; digit0=31; dp[0]=1 after frame_valid.
- Multi-hot: seg_en=1100 held 10 cycles. Required: en_err pulses exactly once; no mask change; a later clean scan still completes a frame.
- Overwrite/order: capture digit 3 as 2, then digit 3 as 9, then digits 2..0. Required: a single frame_valid with digit3=9.
- Reset mid-frame: capture digits 3 and 2, assert rst for 1 cycle, then scan only digits 1 and 0. Required: no frame_valid and digits remain 0.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for seven-segment scan decoding. It holds
//               the segment bit positions, the hex glyph table, the special
//               symbol codes and the scan-tracker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Bit positions on the a_to_g bus
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Special symbol codes
    localparam logic [4:0] SYM_BLANK   = 5'd16;
    localparam logic [4:0] SYM_MINUS   = 5'd17;
    localparam logic [4:0] SYM_INVALID = 5'd31;

    // Glyphs for blank and minus, listed as {a,b,c,d,e,f,g}
    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] PAT_MINUS = 7'b0000001;

    // Hex glyphs, listed as {a,b,c,d,e,f,g}. Index = symbol code.
    localparam logic [0:15][6:0] HEX_PATTERNS = {
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Scan tracker states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2,
        ST_BAD    = 2'd3
    } seg_state_e;

    // True when exactly one digit enable is asserted
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational glyph-to-symbol lookup. Maps the seven segment
//               bits {a..g} to a 5-bit symbol code. Unknown glyphs map to
//               SYM_INVALID.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [4:0] o_sym
);

    // Look the glyph up in the hex table, then handle blank/minus specially
    always_comb begin
        o_sym = SYM_INVALID;
        if (i_seg == PAT_BLANK) begin
            o_sym = SYM_BLANK;
        end else if (i_seg == PAT_MINUS) begin
            o_sym = SYM_MINUS;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i_seg == HEX_PATTERNS[i]) begin
                    o_sym = 5'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Watches a multiplexed seven-segment bus and rebuilds the
//               symbol and decimal point of each of four digits. A digit is
//               accepted only after STABLE_CYCLES identical samples. A frame
//               is published once all four digits have been captured.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a_to_g,
    input  logic [3:0]  seg_en,
    output logic [19:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        pat_err,
    output logic        en_err
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [11:0]      w_in;
    logic [11:0]      r_sample;
    logic             w_changed;
    logic [4:0]       w_sym;
    seg_state_e       r_state;
    seg_state_e       w_entry_state;
    logic             w_reenter;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_capture;
    logic [3:0]       r_mask;
    logic [3:0]       w_mask_base;
    logic [19:0]      r_stage_sym;
    logic [3:0]       r_stage_dp;
    logic [19:0]      r_digits;
    logic [3:0]       r_dp;
    logic             r_frame_valid;
    logic             r_pat_err;
    logic             r_en_err;

    assign w_in      = {a_to_g, seg_en};
    assign w_changed = (w_in != r_sample);
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // A digit is accepted when its run of identical samples reaches the limit
    assign w_capture = (r_state == ST_SETTLE) && !w_changed && (w_cnt_inc == c_CNT_LAST);

    // Drop a completed frame from the mask; a same-cycle capture starts the next one
    assign w_mask_base = (r_mask == 4'b1111) ? 4'b0000 : r_mask;

    seg7_pattern_decode u_decode (
        .i_seg (a_to_g[SEG_A:SEG_G]),
        .o_sym (w_sym)
    );

    // Classify the current enables into the state a new run starts in
    always_comb begin
        w_entry_state = ST_BAD;
        if (seg_en == 4'b0000) begin
            w_entry_state = ST_IDLE;
        end else if (is_onehot4(seg_en)) begin
            w_entry_state = ST_SETTLE;
        end
        // IDLE leaves as soon as any enable shows up; other states leave on change
        w_reenter = (r_state == ST_IDLE) ? (seg_en != 4'b0000) : w_changed;
    end

    // Register the previous bus value for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
        end else begin
            r_sample <= w_in;
        end
    end

    // Scan tracker: stability counting, digit acceptance and enable-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_en_err <= 1'b0;
        end else begin
            r_en_err <= 1'b0;
            if (w_reenter) begin
                r_state  <= w_entry_state;
                r_cnt    <= '0;
                // Only the first cycle of a multi-hot run is reported
                r_en_err <= (w_entry_state == ST_BAD) && (r_state != ST_BAD);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                    end
                    ST_SETTLE: begin
                        r_cnt <= w_cnt_inc;
                        if (w_capture) begin
                            r_state <= ST_HELD;
                        end
                    end
                    default: begin
                        r_cnt <= r_cnt;
                    end
                endcase
            end
        end
    end

    // Staging slots, capture mask and frame publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask        <= 4'b0000;
            r_stage_sym   <= '0;
            r_stage_dp    <= 4'b0000;
            r_digits      <= '0;
            r_dp          <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_pat_err     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_pat_err     <= 1'b0;
            if (r_mask == 4'b1111) begin
                r_digits      <= r_stage_sym;
                r_dp          <= r_stage_dp;
                r_frame_valid <= 1'b1;
            end
            if (w_capture) begin
                for (int k = 0; k < 4; k++) begin
                    if (seg_en[k]) begin
                        r_stage_sym[5*k +: 5] <= w_sym;
                        r_stage_dp[k]         <= a_to_g[SEG_DP];
                    end
                end
                r_pat_err <= (w_sym == SYM_INVALID);
                r_mask    <= w_mask_base | seg_en;
            end else begin
                r_mask    <= w_mask_base;
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign frame_valid = r_frame_valid;
    assign pat_err     = r_pat_err;
    assign en_err      = r_en_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder. Directed scans plus
//               a random scan, compared every cycle with a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int S = 4;

    localparam logic [6:0] P1    = 7'b0110000;
    localparam logic [6:0] P2    = 7'b1101101;
    localparam logic [6:0] P3    = 7'b1111001;
    localparam logic [6:0] P6    = 7'b1011111;
    localparam logic [6:0] P8    = 7'b1111111;
    localparam logic [6:0] P9    = 7'b1111011;
    localparam logic [6:0] PC    = 7'b1001110;
    localparam logic [6:0] PBAD  = 7'b1010101;
    localparam logic [6:0] PBLNK = 7'b0000000;
    localparam logic [6:0] PMIN  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_to_g;
    logic [3:0]  seg_en;
    logic [19:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        pat_err;
    logic        en_err;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_to_g      (a_to_g),
        .seg_en      (seg_en),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .pat_err     (pat_err),
        .en_err      (en_err)
    );

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int pe_cnt = 0;
    int ee_cnt = 0;

    logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: runs of identical bus values, staged digits, published frame
    logic [11:0] m_prev;
    int          m_run;
    logic [4:0]  m_stage [4];
    logic [3:0]  m_stage_dp;
    logic [3:0]  m_mask;
    bit          m_full;
    logic [19:0] m_digits;
    logic [3:0]  m_dp;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'b0000000) return 5'd16;
        if (p == 7'b0000001) return 5'd17;
        for (int i = 0; i < 16; i++) if (tbl[i] == p) return 5'(i);
        return 5'd31;
    endfunction

    task automatic m_reset();
        m_prev = '0; m_run = 0; m_stage_dp = '0; m_mask = '0; m_full = 0;
        m_digits = '0; m_dp = '0;
        for (int k = 0; k < 4; k++) m_stage[k] = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] seg, input logic [3:0] en);
        logic [11:0] x;
        logic [4:0]  s;
        bit cap, efv, epe, eee;
        rst = r; a_to_g = seg; seg_en = en;
        @(posedge clk); #1;
        x = {seg, en};
        efv = 0; epe = 0; eee = 0;
        if (r) begin
            m_reset();
        end else begin
            efv = m_full;
            if (m_full) begin
                m_digits = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
                m_dp = m_stage_dp; m_mask = '0; m_full = 0;
            end
            if (x == m_prev) m_run++; else m_run = 1;
            cap = ($countones(en) == 1) && (m_run == S);
            eee = ($countones(en) > 1) && (x != m_prev) && ($countones(m_prev[3:0]) <= 1);
            s = ref_decode(seg[7:1]);
            epe = cap && (s == 5'd31);
            if (cap) begin
                for (int k = 0; k < 4; k++) begin
                    if (en[k]) begin
                        m_stage[k] = s; m_stage_dp[k] = seg[0]; m_mask[k] = 1'b1;
                    end
                end
                if (m_mask == 4'hF) m_full = 1;
            end
            m_prev = x;
        end
        if (frame_valid === 1'b1) fv_cnt++;
        if (pat_err === 1'b1) pe_cnt++;
        if (en_err === 1'b1) ee_cnt++;
        check("frame_valid", 32'(frame_valid), 32'(efv));
        check("pat_err", 32'(pat_err), 32'(epe));
        check("en_err", 32'(en_err), 32'(eee));
        check("digits", 32'(digits), 32'(m_digits));
        check("dp", 32'(dp), 32'(m_dp));
    endtask

    task automatic hold(input logic [6:0] p, input logic d, input logic [3:0] en, input int n);
        for (int i = 0; i < n; i++) step(1'b0, {p, d}, en);
    endtask

    task automatic show(input logic [6:0] p, input logic d, input logic [3:0] en);
        hold(p, d, en, 6);
        step(1'b0, 8'h00, 4'h0);
    endtask

    int f0, p0, e0;

    initial begin
        m_reset();
        rst = 1'b1; a_to_g = '0; seg_en = '0;

        // Reset state
        step(1'b1, 8'h00, 4'h0);
        step(1'b1, 8'hFF, 4'hF);
        check("reset_digits", 32'(digits), 32'd0);
        check("reset_dp", 32'(dp), 32'd0);
        check("reset_flags", 32'({frame_valid, pat_err, en_err}), 32'd0);

        // Clean frame: 1, 6, blank, minus
        f0 = fv_cnt; p0 = pe_cnt; e0 = ee_cnt;
        show(P1, 1'b0, 4'b1000);
        show(P6, 1'b0, 4'b0100);
        show(PBLNK, 1'b0, 4'b0010);
        show(PMIN, 1'b0, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 2);
        check("clean_frames", 32'(fv_cnt - f0), 32'd1);
        check("clean_digits", 32'(digits), 32'({5'd1, 5'd6, 5'd16, 5'd17}));
        check("clean_dp", 32'(dp), 32'd0);
        check("clean_errs", 32'(pe_cnt - p0 + ee_cnt - e0), 32'd0);

        // Glitch: "8" for one cycle short of acceptance, then "C"
        show(P1, 1'b0, 4'b1000);
        hold(P8, 1'b0, 4'b0100, S - 1);
        hold(PC, 1'b0, 4'b0100, 6);
        step(1'b0, 8'h00, 4'h0);
        show(P1, 1'b0, 4'b0010);
        show(P1, 1'b0, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 2);
        check("glitch_digit2", 32'(digits[14:10]), 32'd12);

        // Invalid glyph on digit 0 with its decimal point lit
        p0 = pe_cnt;
        show(P3, 1'b0, 4'b1000);
        show(P2, 1'b0, 4'b0100);
        show(P1, 1'b0, 4'b0010);
        show(PBAD, 1'b1, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 2);
        check("invalid_pat_err", 32'(pe_cnt - p0), 32'd1);
        check("invalid_digit0", 32'(digits[4:0]), 32'd31);
        check("invalid_dp0", 32'(dp[0]), 32'd1);

        // Multi-hot enables in the middle of a frame
        f0 = fv_cnt; e0 = ee_cnt;
        show(P2, 1'b0, 4'b1000);
        show(P3, 1'b0, 4'b0100);
        hold(P8, 1'b0, 4'b1100, 10);
        step(1'b0, 8'h00, 4'h0);
        check("multi_en_err", 32'(ee_cnt - e0), 32'd1);
        check("multi_no_frame", 32'(fv_cnt - f0), 32'd0);
        show(P6, 1'b0, 4'b0010);
        show(P9, 1'b0, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 2);
        check("multi_frame", 32'(fv_cnt - f0), 32'd1);
        check("multi_digits", 32'(digits), 32'({5'd2, 5'd3, 5'd6, 5'd9}));

        // Overwrite of digit 3 before the frame completes
        f0 = fv_cnt;
        show(P2, 1'b0, 4'b1000);
        show(P9, 1'b0, 4'b1000);
        show(P1, 1'b0, 4'b0100);
        show(P1, 1'b0, 4'b0010);
        show(P1, 1'b0, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 2);
        check("overwrite_frames", 32'(fv_cnt - f0), 32'd1);
        check("overwrite_digit3", 32'(digits[19:15]), 32'd9);

        // Reset mid-frame discards the partial frame
        show(P1, 1'b0, 4'b1000);
        show(P6, 1'b0, 4'b0100);
        step(1'b1, 8'h00, 4'h0);
        f0 = fv_cnt;
        show(P1, 1'b0, 4'b0010);
        show(P1, 1'b0, 4'b0001);
        hold(PBLNK, 1'b0, 4'h0, 3);
        check("reset_mid_frames", 32'(fv_cnt - f0), 32'd0);
        check("reset_mid_digits", 32'(digits), 32'd0);

        // Random scan against the model
        for (int r = 0; r < 120; r++) begin
            logic [6:0] p;
            logic [3:0] en;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 16) p = tbl[sel];
            else if (sel == 16) p = 7'b0000000;
            else if (sel == 17) p = 7'b0000001;
            else p = 7'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) en = 4'h0;
            else if (sel < 8) en = 4'(1 << $urandom_range(0, 3));
            else begin
                en = 4'h3;
                while ($countones(en) < 2) en = 4'($urandom);
                en = (en == 4'h0) ? 4'h3 : en;
            end
            hold(p, 1'($urandom), en, $urandom_range(1, 8));
        end
        hold(PBLNK, 1'b0, 4'h0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
